// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block COPY/FILL initiator for the single-port data RAM
module mem_copy_engine #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [DATA_WIDTH-1:0]             src_addr,
    input  logic [DATA_WIDTH-1:0]             dst_addr,
    input  logic [$clog2(MEMORY_DEPTH):0]     length,
    input  logic [DATA_WIDTH-1:0]             fill_value,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [$clog2(MEMORY_DEPTH):0]     words_done,
    output logic [DATA_WIDTH-1:0]             mem_address,
    output logic [DATA_WIDTH-1:0]             mem_write_data,
    output logic                              mem_write_enable,
    input  logic [DATA_WIDTH-1:0]             mem_read_data
);

    localparam int CW = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [DATA_WIDTH:0] DEPTH_W = (DATA_WIDTH + 1)'(MEMORY_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                 state, next_state;
    logic                   mode_q;
    logic [DATA_WIDTH-1:0]  src_q, dst_q, fill_q, buf_q, wdata_q;
    logic [CW-1:0]          len_q;
    logic                   accept, req_ok;
    logic [DATA_WIDTH-1:0]  word_off, cur_wdata;

    // Offset arithmetic is one bit wider so huge addresses cannot wrap into range.
    function automatic logic range_ok(input logic [DATA_WIDTH-1:0] addr,
                                      input logic [CW-1:0]         len);
        logic [DATA_WIDTH:0] end_word;
        end_word = {1'b0, (addr - BASE_ADDR) >> 2} + {{(DATA_WIDTH + 1 - CW){1'b0}}, len};
        return (addr >= BASE_ADDR) && (end_word <= DEPTH_W);
    endfunction

    assign accept    = (state == S_IDLE) && start;
    assign req_ok    = (dst_addr[1:0] == 2'b00) && range_ok(dst_addr, length) &&
                       (mode || ((src_addr[1:0] == 2'b00) && range_ok(src_addr, length)));
    assign word_off  = {{(DATA_WIDTH - CW - 2){1'b0}}, words_done, 2'b00};
    assign cur_wdata = mode_q ? fill_q : buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        busy             = 1'b0;
        done             = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = BASE_ADDR;
        mem_write_data   = wdata_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!req_ok || (length == '0)) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = mode ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                busy        = 1'b1;
                mem_address = src_q + word_off;
                next_state  = S_WRITE;
            end
            S_WRITE: begin
                busy             = 1'b1;
                mem_address      = dst_q + word_off;
                mem_write_enable = 1'b1;
                mem_write_data   = cur_wdata;
                if ((words_done + CW'(1)) < len_q) begin
                    next_state = mode_q ? S_WRITE : S_READ;
                end else begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            buf_q      <= '0;
            wdata_q    <= '0;
            words_done <= '0;
            error      <= 1'b0;
        end else if (accept) begin
            mode_q     <= mode;
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= length;
            fill_q     <= fill_value;
            words_done <= '0;
            error      <= !req_ok;
        end else if (state == S_READ) begin
            buf_q <= mem_read_data;
        end else if (state == S_WRITE) begin
            wdata_q    <= cur_wdata;
            words_done <= words_done + CW'(1);
        end
    end

endmodule
